// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Front-end for active-low board push-buttons (SLC-3 Run/Continue and any
// further keys). Each channel is synchronised to Clk, debounced with a
// programmable hold time, and turned into a debounced level plus single-cycle
// press and release pulses. Channels are fully independent.
//
// Optional feature: define BTN_AUTOREPEAT_EN to build auto-repeat. While a
// button stays pressed, an extra Press pulse fires REPEAT_DELAY cycles after
// the original Press, then every REPEAT_PERIOD cycles. Without the macro the
// REPEAT_* parameters have no effect and only RELEASED/PRESSED states exist.
//
// Parameters:
//   N_BTN         number of button channels (>=1)
//   DEBOUNCE_CYC  consecutive mismatching samples needed to accept a change
//   REPEAT_DELAY  cycles from Press to first repeat (auto-repeat only)
//   REPEAT_PERIOD cycles between subsequent repeats (auto-repeat only)
//
// Ports:
//   Clk      in   1      single clock
//   Reset_n  in   1      asynchronous active-low reset
//   Btn_n    in   N_BTN  raw buttons, 0 = pressed, asynchronous to Clk
//   Level    out  N_BTN  debounced state, 1 = pressed (registered)
//   Press    out  N_BTN  one-cycle pulse per accepted press / repeat (registered)
//   Release  out  N_BTN  one-cycle pulse per accepted release (registered)
// -----------------------------------------------------------------------------
module button_conditioner #(
   parameter int N_BTN         = 2,
   parameter int DEBOUNCE_CYC  = 16,
   parameter int REPEAT_DELAY  = 32,
   parameter int REPEAT_PERIOD = 8
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [N_BTN-1:0] Btn_n,
   output logic [N_BTN-1:0] Level,
   output logic [N_BTN-1:0] Press,
   output logic [N_BTN-1:0] Release
);

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // One counter width serves both the debounce and the repeat counters.
   localparam int MAX_CYC = max3(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD);
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_RELEASED,
      ST_PRESSED,
      ST_HOLD,
      ST_REPEAT
   } state_t;
`else
   typedef enum logic {
      ST_RELEASED,
      ST_PRESSED
   } state_t;
`endif

   // Two-flop synchroniser; resets to "released" (1) so a key held through
   // reset is seen as a fresh press once reset lifts.
   logic [N_BTN-1:0] sync1_q;
   logic [N_BTN-1:0] sync2_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= Btn_n;
         sync2_q <= sync1_q;
      end
   end

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      logic             s;
      logic             mismatch;
      logic             accept;
      logic             acc_press;
      logic             acc_release;
      logic [CNT_W-1:0] db_cnt_q;
      logic [CNT_W-1:0] db_cnt_d;
      logic             level_q;
      logic             level_d;
      logic             press_q;
      logic             press_d;
      logic             release_q;
      logic             release_d;
      state_t           state_q;
      state_t           state_d;
`ifdef BTN_AUTOREPEAT_EN
      logic [CNT_W-1:0] rep_cnt_q;
      logic [CNT_W-1:0] rep_cnt_d;
`endif

      assign s        = ~sync2_q[g];
      assign mismatch = s ^ level_q;
      // A change is accepted on the DEBOUNCE_CYC-th uninterrupted mismatch.
      assign accept      = mismatch && (db_cnt_q == DB_LAST);
      assign acc_press   = accept & s;
      assign acc_release = accept & ~s;

      // Any matching sample (bounce) restarts the count from zero.
      always_comb begin
         db_cnt_d = '0;
         if (mismatch && !accept) begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
         level_d = level_q ^ accept;
      end

      always_comb begin
         state_d   = state_q;
         press_d   = 1'b0;
         release_d = acc_release;
`ifdef BTN_AUTOREPEAT_EN
         rep_cnt_d = '0;
`endif
         case (state_q)
            ST_RELEASED: begin
               if (acc_press) begin
                  state_d = ST_PRESSED;
                  press_d = 1'b1;
               end
            end
`ifdef BTN_AUTOREPEAT_EN
            // PRESSED is the cycle of the original pulse; it and HOLD both
            // count towards the first repeat, so the delay is measured from
            // the Press cycle itself.
            ST_PRESSED, ST_HOLD: begin
               if (rep_cnt_q == RD_LAST) begin
                  state_d = ST_REPEAT;
                  press_d = 1'b1;
               end else begin
                  state_d   = ST_HOLD;
                  rep_cnt_d = rep_cnt_q + 1'b1;
               end
            end
            ST_REPEAT: begin
               if (rep_cnt_q == RP_LAST) begin
                  press_d = 1'b1;
               end else begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
               end
            end
`else
            ST_PRESSED: begin
               state_d = ST_PRESSED;
            end
`endif
            default: begin
               state_d = ST_RELEASED;
            end
         endcase

         // Release overrides everything, including a repeat due this cycle.
         if (acc_release) begin
            state_d = ST_RELEASED;
            press_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt_d = '0;
`endif
         end
      end

      always_ff @(posedge Clk or negedge Reset_n) begin
         if (!Reset_n) begin
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            state_q   <= ST_RELEASED;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt_q <= '0;
`endif
         end else begin
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            state_q   <= state_d;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt_q <= rep_cnt_d;
`endif
         end
      end

      assign Level[g]   = level_q;
      assign Press[g]   = press_q;
      assign Release[g] = release_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with N_BTN=2, DEBOUNCE_CYC=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=4. Inputs change 1 ns after a rising edge, so
// the next rising edge is E0; after the k-th tick the bench sits just past Ek.
// Define BTN_AUTOREPEAT_EN for both files to exercise the repeat scenario.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

   logic       Clk;
   logic       Reset_n;
   logic [1:0] Btn_n;
   logic [1:0] Level;
   logic [1:0] Press;
   logic [1:0] Release;

   int n_vec;
   int n_err;

   button_conditioner #(
      .N_BTN        (2),
      .DEBOUNCE_CYC (4),
      .REPEAT_DELAY (8),
      .REPEAT_PERIOD(4)
   ) dut (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .Btn_n  (Btn_n),
      .Level  (Level),
      .Press  (Press),
      .Release(Release)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [1:0] lvl,
                             input logic [1:0] prs, input logic [1:0] rel);
      check({tag, ".level"},   32'(Level),   32'(lvl));
      check({tag, ".press"},   32'(Press),   32'(prs));
      check({tag, ".release"}, 32'(Release), 32'(rel));
   endtask

   logic [6:0] bounce_pat;

   initial begin
      n_vec   = 0;
      n_err   = 0;
      Reset_n = 1'b0;
      Btn_n   = 2'b00;

      // Reset with both buttons held: everything must stay low.
      for (int k = 0; k < 3; k++) begin
         tick();
         expect_out($sformatf("reset_k%0d", k), 2'b00, 2'b00, 2'b00);
      end

      // Buttons held through reset release appear as new presses at E5.
      Reset_n = 1'b1;
      for (int k = 0; k < 9; k++) begin
         tick();
         expect_out($sformatf("post_rst_k%0d", k),
                    (k >= 5) ? 2'b11 : 2'b00, (k == 5) ? 2'b11 : 2'b00, 2'b00);
      end

      // Release both: simultaneous Release pulses at E5.
      Btn_n = 2'b11;
      for (int k = 0; k < 9; k++) begin
         tick();
         expect_out($sformatf("rel_both_k%0d", k),
                    (k >= 5) ? 2'b00 : 2'b11, 2'b00, (k == 5) ? 2'b11 : 2'b00);
      end

      // Glitch: 3 low samples is rejected.
      Btn_n = 2'b10;
      for (int k = 0; k < 3; k++) tick();
      Btn_n = 2'b11;
      for (int k = 0; k < 8; k++) begin
         tick();
         expect_out($sformatf("glitch3_k%0d", k), 2'b00, 2'b00, 2'b00);
      end

      // Exactly 4 low samples is accepted at E5.
      Btn_n = 2'b10;
      for (int k = 0; k < 4; k++) begin
         tick();
         expect_out($sformatf("pulse4_k%0d", k), 2'b00, 2'b00, 2'b00);
      end
      Btn_n = 2'b11;
      for (int k = 4; k < 8; k++) begin
         tick();
         expect_out($sformatf("pulse4_k%0d", k),
                    (k == 5 || k == 6 || k == 7) ? 2'b01 : 2'b00,
                    (k == 5) ? 2'b01 : 2'b00, 2'b00);
      end
      // Sync sees high from E5 on, so release is accepted at E9.
      for (int k = 8; k < 12; k++) begin
         tick();
         expect_out($sformatf("pulse4_rel_k%0d", k),
                    (k < 9) ? 2'b01 : 2'b00, 2'b00, (k == 9) ? 2'b01 : 2'b00);
      end

      // Bounce low,low,high,low,low,low,low: single Press at E8.
      bounce_pat = 7'b0000100;
      for (int k = 0; k < 13; k++) begin
         Btn_n[0] = (k < 7) ? bounce_pat[k] : 1'b0;
         tick();
         expect_out($sformatf("bounce_k%0d", k),
                    (k >= 8) ? 2'b01 : 2'b00, (k == 8) ? 2'b01 : 2'b00, 2'b00);
      end
      Btn_n = 2'b11;
      for (int k = 0; k < 10; k++) tick();
      expect_out("bounce_released", 2'b00, 2'b00, 2'b00);

      // Independence: both pressed together, then only ch0 released.
      Btn_n = 2'b00;
      for (int k = 0; k < 8; k++) begin
         tick();
         expect_out($sformatf("indep_press_k%0d", k),
                    (k >= 5) ? 2'b11 : 2'b00, (k == 5) ? 2'b11 : 2'b00, 2'b00);
      end
      Btn_n = 2'b01;
      for (int k = 0; k < 8; k++) begin
         tick();
         expect_out($sformatf("indep_rel0_k%0d", k),
                    (k >= 5) ? 2'b10 : 2'b11, 2'b00, (k == 5) ? 2'b01 : 2'b00);
      end
      Btn_n = 2'b11;
      for (int k = 0; k < 10; k++) tick();
      expect_out("indep_released", 2'b00, 2'b00, 2'b00);

      // Mid-count reset: the partial count must be discarded.
      Btn_n = 2'b10;
      for (int k = 0; k < 3; k++) tick();
      Reset_n = 1'b0;
      tick();
      expect_out("midrst_in_reset", 2'b00, 2'b00, 2'b00);
      Reset_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         expect_out($sformatf("midrst_k%0d", k),
                    (k >= 5) ? 2'b01 : 2'b00, (k == 5) ? 2'b01 : 2'b00, 2'b00);
      end
      // Release lands on the cycle a first repeat would be due (8 after
      // Press); no Press may accompany the Release.
      Btn_n = 2'b11;
      for (int k = 0; k < 8; k++) begin
         tick();
         expect_out($sformatf("midrst_rel_k%0d", k),
                    (k >= 5) ? 2'b00 : 2'b01, 2'b00, (k == 5) ? 2'b01 : 2'b00);
      end

`ifdef BTN_AUTOREPEAT_EN
      // Auto-repeat: Press at E5, repeats at E13, E17, E21.
      Btn_n = 2'b10;
      for (int k = 0; k < 23; k++) begin
         tick();
         expect_out($sformatf("rep_k%0d", k),
                    (k >= 5) ? 2'b01 : 2'b00,
                    (k == 5 || k == 13 || k == 17 || k == 21) ? 2'b01 : 2'b00,
                    2'b00);
      end
      // Released before E23; Level still 1 at E25 so that repeat fires,
      // then Release at E28 and nothing after.
      Btn_n = 2'b11;
      for (int k = 0; k < 12; k++) begin
         tick();
         expect_out($sformatf("rep_rel_k%0d", k),
                    (k >= 5) ? 2'b00 : 2'b01,
                    (k == 2) ? 2'b01 : 2'b00,
                    (k == 5) ? 2'b01 : 2'b00);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised front-end for the board push-buttons that drive the SLC-3 `Run` and `Continue` controls, and any further control keys. It synchronises each active-low raw button to `Clk`, rejects bounce shorter than a programmable hold time, and produces a debounced level plus single-cycle press and release pulses. The processor and its testbenches consume these pulses instead of raw key levels. Channel count and debounce time are parameters. Auto-repeat is an optional compiled-in mode.

## Interface
Parameters:
- `N_BTN`, 2: number of independent button channels (≥1).
- `DEBOUNCE_CYC`, 16: consecutive stable cycles required to accept a change (≥1). The board build uses 500000.
- `REPEAT_DELAY`, 32: cycles from the original press to the first repeat pulse (≥1). Used only with auto-repeat.
- `REPEAT_PERIOD`, 8: cycles between subsequent repeat pulses (≥1). Used only with auto-repeat.

Ports:
- `Clk`, in, 1: single clock for all logic.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `Btn_n`, in, N_BTN: raw buttons, 0 = pressed. These are asynchronous to `Clk`.
- `Level`, out, N_BTN: debounced state, 1 = pressed.
- `Press`, out, N_BTN: one-cycle pulse on an accepted press, and on each auto-repeat.
- `Release`, out, N_BTN: one-cycle pulse on an accepted release.

All outputs are registered. Channels are fully independent.

## Operation
- Per channel, a 2-flop synchroniser on `Btn_n` feeds `s`. `s` is inverted, so 1 = pressed.
- Per channel, a debounce counter, width `$clog2(max(DEBOUNCE_CYC,REPEAT_DELAY,REPEAT_PERIOD)+1)`:
  - If `s != Level`, the counter increments.
  - If `s == Level`, the counter clears.
  - When `s != Level` and the counter equals `DEBOUNCE_CYC-1`, `Level` toggles and the counter clears.
- `Press` is 1 in exactly the cycle following a 0→1 `Level` edge. `Release` behaves the same for a 1→0 edge. At most one of the two is asserted per channel per cycle.
- Per-channel FSM:
  - States are `RELEASED` and `PRESSED`, plus `HOLD` and `REPEAT` when auto-repeat is built.
  - `RELEASED`→`PRESSED` on an accepted press.
  - Any state →`RELEASED` on an accepted release.
- A bounce inside the debounce window restarts the count. Only `DEBOUNCE_CYC` uninterrupted mismatching samples cause a change.
- Reset values:
  - Synchroniser flops are 1 (released).
  - `Level`, `Press`, `Release` and all counters are 0.
  - FSM state is `RELEASED`.
- Reset asserted mid-count discards the partial count.
- A button held through reset release is seen as a new press and produces `Press` after the normal latency.

## Timing
- Edge numbering: E0 is the first `Clk` edge that samples a new `Btn_n` value.
- The synchroniser output reflects the new value after E1.
- `Level` changes at E(1+DEBOUNCE_CYC). `Press` or `Release` is high for the cycle after that same edge.
- An input pulse or glitch sampled on fewer than `DEBOUNCE_CYC` consecutive edges produces no output change. Exactly `DEBOUNCE_CYC` samples is accepted.
- Simultaneous events on multiple channels produce simultaneous pulses. There is no arbitration or serialisation.
- Throughput: one accepted transition per channel per `DEBOUNCE_CYC` cycles at most.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - While `Level` stays 1, an additional `Press` pulse occurs `REPEAT_DELAY` cycles after the original `Press` cycle.
  - Further pulses then follow every `REPEAT_PERIOD` cycles.
  - The repeat counter is separate from the debounce counter. Bounce that does not change `Level` does not disturb it.
  - An accepted release cancels repetition immediately. No `Press` pulse is issued in the same cycle as `Release`.
- `BTN_AUTOREPEAT_EN` not defined:
  - The `REPEAT_*` parameters are ignored and there is no `HOLD`/`REPEAT` logic.
  - There is exactly one `Press` per accepted press.

## Test plan
All scenarios use `N_BTN`=2, `DEBOUNCE_CYC`=4 unless stated.
- Reset: hold `Reset_n`=0 with `Btn_n`=2'b00 → all outputs 0. Release reset → `Level`[1:0]=2'b11 four debounce cycles after sync, each `Press` bit high for exactly one cycle.
- Glitch rejection: `Btn_n`[0] low for 3 edges, then high → `Level`, `Press` stay 0. Low for 4 edges → `Level`[0]=1 at E5, `Press`[0] pulse then.
- Bounce: `Btn_n`[0] pattern low,low,high,low,low,low,low → a single `Press`[0], at the edge after the fourth consecutive low sync sample. No double pulse.
- Release plus independence: hold ch0 and press ch1 at the same E0 → both `Press` bits pulse at E5. Release ch0 only → `Release`[0]=1 for one cycle, `Level`=2'b10.
- Mid-count reset: `Btn_n`[0] low for 3 edges, assert `Reset_n` for 1 cycle, keep low → `Press`[0] at E(post-reset)+5, not earlier.
- Auto-repeat (`BTN_AUTOREPEAT_EN`, `REPEAT_DELAY`=8, `REPEAT_PERIOD`=4): press ch0 held 20 cycles after the first `Press` at E5 → further pulses at E13, E17, E21. Release → `Release`[0] pulse and no further `Press`.
